// File: rtl/riscv_alu_mc.sv
// Multi-cycle RV32I/RV64I + M-extension execute unit with valid/ready handshakes on both sides.
// Define RISCV_ALU_FAST_MUL_EN to replace the iterative multiplier with a single-cycle one.
module riscv_alu_mc #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN),
    parameter int CNT_W   = $clog2(XLEN) + 1
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2, ST_DONE = 2'd3} state_t;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_XOR = 5'd2,  OP_OR = 5'd3;
    localparam logic [4:0] OP_AND = 5'd4,  OP_SLL = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_SLT = 5'd8,  OP_SLTU = 5'd9;
    localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
    localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22, OP_REMU = 5'd23;

    localparam logic [XLEN-1:0]  ZERO_X   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     opd_r;
    logic [4:0]          op_r;
    logic                neg_res_r;
    logic                neg_rem_r;
    logic [XLEN-1:0]     result_r;

    logic                accept_s, is_mul_s, is_div_s, iter_mul_s;
    logic                a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]     a_mag_s, b_mag_s;
    logic                b_zero_s, ovf_s, div_special_s;
    logic [SHAMT_W-1:0]  shamt_s;
    logic [XLEN-1:0]     base_res_s, special_res_s;
    logic [XLEN:0]       mul_sum_s, div_shift_s, div_trial_s;
    logic [2*XLEN-1:0]   mul_next_s, div_next_s, mul_prod_s;
    logic [XLEN-1:0]     quo_fix_s, rem_fix_s, mul_res_s, div_res_s;

    assign o_ready  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & i_ready);
    assign o_valid  = (state_r == ST_DONE);
    assign o_busy   = (state_r == ST_MUL) | (state_r == ST_DIV);
    assign o_result = result_r;
    assign accept_s = i_valid & o_ready;

    assign is_mul_s   = (i_op == OP_MUL) | (i_op == OP_MULH) | (i_op == OP_MULHSU) | (i_op == OP_MULHU);
    assign is_div_s   = (i_op == OP_DIV) | (i_op == OP_DIVU) | (i_op == OP_REM) | (i_op == OP_REMU);
    assign a_signed_s = (i_op == OP_MULH) | (i_op == OP_MULHSU) | (i_op == OP_DIV) | (i_op == OP_REM);
    assign b_signed_s = (i_op == OP_MULH) | (i_op == OP_DIV) | (i_op == OP_REM);
    assign a_neg_s    = a_signed_s & i_a[XLEN-1];
    assign b_neg_s    = b_signed_s & i_b[XLEN-1];
    assign a_mag_s    = a_neg_s ? -i_a : i_a;
    assign b_mag_s    = b_neg_s ? -i_b : i_b;
    assign b_zero_s   = (i_b == ZERO_X);
    assign ovf_s      = ((i_op == OP_DIV) | (i_op == OP_REM)) & (i_a == MOST_NEG) & (i_b == ALL_ONES);
    assign div_special_s = b_zero_s | ovf_s;
    assign shamt_s    = i_b[SHAMT_W-1:0];

`ifdef RISCV_ALU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_s;
    // Sign-extend to 2*XLEN so one unsigned multiply yields every high/low variant.
    assign fast_prod_s = {{XLEN{a_signed_s & i_a[XLEN-1]}}, i_a} * {{XLEN{b_signed_s & i_b[XLEN-1]}}, i_b};
    assign iter_mul_s  = 1'b0;
`else
    assign iter_mul_s  = is_mul_s;
`endif

    // Single-cycle result for base ops (and fast multiplies); illegal ops yield zero.
    always_comb begin
        base_res_s = ZERO_X;
        case (i_op)
            OP_ADD:  base_res_s = i_a + i_b;
            OP_SUB:  base_res_s = i_a - i_b;
            OP_XOR:  base_res_s = i_a ^ i_b;
            OP_OR:   base_res_s = i_a | i_b;
            OP_AND:  base_res_s = i_a & i_b;
            OP_SLL:  base_res_s = i_a << shamt_s;
            OP_SRL:  base_res_s = i_a >> shamt_s;
            OP_SRA:  base_res_s = $unsigned($signed(i_a) >>> shamt_s);
            OP_SLT:  base_res_s = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLTU: base_res_s = {{(XLEN-1){1'b0}}, (i_a < i_b)};
`ifdef RISCV_ALU_FAST_MUL_EN
            OP_MUL:    base_res_s = fast_prod_s[XLEN-1:0];
            OP_MULH:   base_res_s = fast_prod_s[2*XLEN-1:XLEN];
            OP_MULHSU: base_res_s = fast_prod_s[2*XLEN-1:XLEN];
            OP_MULHU:  base_res_s = fast_prod_s[2*XLEN-1:XLEN];
`endif
            default: base_res_s = ZERO_X;
        endcase
    end

    // Divide-by-zero and signed-overflow results that bypass the iterative divider.
    always_comb begin
        special_res_s = ZERO_X;
        if (b_zero_s) begin
            special_res_s = ((i_op == OP_DIV) | (i_op == OP_DIVU)) ? ALL_ONES : i_a;
        end else if (i_op == OP_DIV) begin
            special_res_s = MOST_NEG;
        end else begin
            special_res_s = ZERO_X;
        end
    end

    // One shift-add multiply step and one restoring divide step over the shared accumulator.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opd_r} : {(XLEN+1){1'b0}});
        mul_next_s  = {mul_sum_s, acc_r[XLEN-1:1]};
        div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        div_trial_s = div_shift_s - {1'b0, opd_r};
        if (div_trial_s[XLEN]) begin
            div_next_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
        end else begin
            div_next_s = {div_trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        end
        mul_prod_s = neg_res_r ? -mul_next_s : mul_next_s;
        mul_res_s  = (op_r == OP_MUL) ? mul_prod_s[XLEN-1:0] : mul_prod_s[2*XLEN-1:XLEN];
        quo_fix_s  = neg_res_r ? -div_next_s[XLEN-1:0] : div_next_s[XLEN-1:0];
        rem_fix_s  = neg_rem_r ? -div_next_s[2*XLEN-1:XLEN] : div_next_s[2*XLEN-1:XLEN];
        div_res_s  = ((op_r == OP_DIV) | (op_r == OP_DIVU)) ? quo_fix_s : rem_fix_s;
    end

    // Control FSM with latched operands; the result register only changes when a result is produced.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {(2*XLEN){1'b0}};
            opd_r     <= ZERO_X;
            op_r      <= 5'd0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            result_r  <= ZERO_X;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        op_r <= i_op;
                        if (iter_mul_s) begin
                            state_r   <= ST_MUL;
                            cnt_r     <= CNT_W'(XLEN);
                            acc_r     <= {ZERO_X, b_mag_s};
                            opd_r     <= a_mag_s;
                            neg_res_r <= a_neg_s ^ b_neg_s;
                            neg_rem_r <= 1'b0;
                        end else if (is_div_s && !div_special_s) begin
                            state_r   <= ST_DIV;
                            cnt_r     <= CNT_W'(XLEN);
                            acc_r     <= {ZERO_X, a_mag_s};
                            opd_r     <= b_mag_s;
                            neg_res_r <= a_neg_s ^ b_neg_s;
                            neg_rem_r <= a_neg_s;
                        end else begin
                            state_r  <= ST_DONE;
                            result_r <= is_div_s ? special_res_s : base_res_s;
                        end
                    end else if ((state_r == ST_DONE) && i_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_MUL: begin
                    acc_r <= mul_next_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        result_r <= mul_res_s;
                        state_r  <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    acc_r <= div_next_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        result_r <= div_res_s;
                        state_r  <= ST_DONE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_alu_mc.sv
// Self-checking bench for riscv_alu_mc: expected results queued at issue, popped at o_valid.
module tb_riscv_alu_mc;
    localparam int XLEN = 32;
`ifdef RISCV_ALU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, XOR_ = 5'd2, OR_ = 5'd3, AND_ = 5'd4;
    localparam logic [4:0] SLL = 5'd5, SRL = 5'd6, SRA = 5'd7, SLT = 5'd8, SLTU = 5'd9;
    localparam logic [4:0] MUL = 5'd16, MULH = 5'd17, MULHSU = 5'd18, MULHU = 5'd19;
    localparam logic [4:0] DIV = 5'd20, DIVU = 5'd21, REM = 5'd22, REMU = 5'd23;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [4:0]      i_op = 5'd0;
    logic [XLEN-1:0] i_a = 32'd0;
    logic [XLEN-1:0] i_b = 32'd0;
    logic            o_valid;
    logic            i_ready = 1'b1;
    logic [XLEN-1:0] o_result;
    logic            o_busy;

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] exp_q[$];

    riscv_alu_mc #(.XLEN(XLEN)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_valid(o_valid),
        .i_ready(i_ready), .o_result(o_result), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Issue one request from IDLE, wait (bounded) for the result, then let it retire.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_cycles);
        i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_a = $urandom(); i_b = $urandom();
        lat = 1; busy_cycles = 0;
        while (!o_valid && lat < 100) begin
            if (o_busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        res = o_result;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_cmp += 4;
        if (o_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        if (o_result !== 32'd0) begin n_mis++; $display("FAIL reset_result: got %h expected 0", o_result); end
        if (o_busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        if (o_ready !== 1'b1) begin n_mis++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        exp_q.push_back(32'd12); exp_q.push_back(32'hFFFF_FFFE);
        i_op = ADD; i_a = 32'd5; i_b = 32'd7; i_valid = 1'b1; #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_mis++; $display("FAIL b2b_ready0: got %b expected 1", o_ready); end
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        n_cmp += 2;
        if (o_valid !== 1'b1) begin n_mis++; $display("FAIL b2b_add_valid: got %b expected 1", o_valid); end
        if (o_result !== exp) begin n_mis++; $display("FAIL b2b_add: got %h expected %h", o_result, exp); end
        i_op = SUB; i_a = 32'd3; i_b = 32'd5; #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_mis++; $display("FAIL b2b_ready1: got %b expected 1", o_ready); end
        @(posedge clk); #1;
        i_valid = 1'b0;
        exp = exp_q.pop_front();
        n_cmp += 2;
        if (o_valid !== 1'b1) begin n_mis++; $display("FAIL b2b_sub_valid: got %b expected 1", o_valid); end
        if (o_result !== exp) begin n_mis++; $display("FAIL b2b_sub: got %h expected %h", o_result, exp); end
        @(posedge clk); #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_mis++; $display("FAIL b2b_retire: got %b expected 0", o_valid); end
    endtask

    task automatic test_base_ops();
        logic [4:0]  t_op[10];
        logic [31:0] t_a[10], t_b[10], t_e[10];
        logic [31:0] res, exp;
        int lat, busy;
        t_op = '{XOR_, AND_, SLL, SRL, SRA, SLTU, SLT, ADD, OR_, 5'd31};
        t_a  = '{32'hF0F0_F0F0, 32'hFFFF_0000, 32'd1, 32'h8000_0000, 32'h8000_0000,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1200, 32'h1234_5678};
        t_b  = '{32'hFF00_FF00, 32'h1234_5678, 32'd33, 32'd4, 32'd4,
                 32'd1, 32'd1, 32'd1, 32'h0000_0034, 32'h0000_0001};
        t_e  = '{32'h0FF0_0FF0, 32'h1234_0000, 32'd2, 32'h0800_0000, 32'hF800_0000,
                 32'd0, 32'd1, 32'd0, 32'h0000_1234, 32'd0};
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(t_e[i]);
            do_op(t_op[i], t_a[i], t_b[i], res, lat, busy);
            exp = exp_q.pop_front();
            n_cmp += 2;
            if (res !== exp) begin n_mis++; $display("FAIL base_op%0d: got %h expected %h", t_op[i], res, exp); end
            if (lat !== 1) begin n_mis++; $display("FAIL base_lat%0d: got %0d expected 1", t_op[i], lat); end
        end
    endtask

    task automatic test_div();
        logic [4:0]  t_op[4];
        logic [31:0] t_a[4], t_b[4], t_e[4];
        logic [31:0] res, exp;
        int lat, busy;
        t_op = '{DIV, REM, DIVU, REMU};
        t_a  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        t_b  = '{32'd2, 32'd2, 32'd7, 32'd7};
        t_e  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(t_e[i]);
            do_op(t_op[i], t_a[i], t_b[i], res, lat, busy);
            exp = exp_q.pop_front();
            n_cmp += 3;
            if (res !== exp) begin n_mis++; $display("FAIL div_op%0d: got %h expected %h", t_op[i], res, exp); end
            if (lat !== XLEN + 1) begin n_mis++; $display("FAIL div_lat%0d: got %0d expected %0d", t_op[i], lat, XLEN + 1); end
            if (busy !== XLEN) begin n_mis++; $display("FAIL div_busy%0d: got %0d expected %0d", t_op[i], busy, XLEN); end
        end
    endtask

    task automatic test_div_special();
        logic [4:0]  t_op[6];
        logic [31:0] t_a[6], t_b[6], t_e[6];
        logic [31:0] res, exp;
        int lat, busy;
        t_op = '{DIVU, REMU, DIV, REM, DIV, REM};
        t_a  = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
        t_b  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        t_e  = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(t_e[i]);
            do_op(t_op[i], t_a[i], t_b[i], res, lat, busy);
            exp = exp_q.pop_front();
            n_cmp += 2;
            if (res !== exp) begin n_mis++; $display("FAIL divspec%0d: got %h expected %h", i, res, exp); end
            if (lat !== 1) begin n_mis++; $display("FAIL divspec_lat%0d: got %0d expected 1", i, lat); end
        end
    endtask

    task automatic test_mul();
        logic [4:0]  t_op[4];
        logic [31:0] t_a[4], t_b[4], t_e[4];
        logic [31:0] res, exp;
        int lat, busy;
        t_op = '{MULH, MULHSU, MULHU, MUL};
        t_a  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
        t_b  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        t_e  = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFEB};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(t_e[i]);
            do_op(t_op[i], t_a[i], t_b[i], res, lat, busy);
            exp = exp_q.pop_front();
            n_cmp += 3;
            if (res !== exp) begin n_mis++; $display("FAIL mul_op%0d: got %h expected %h", t_op[i], res, exp); end
            if (lat !== MUL_LAT) begin n_mis++; $display("FAIL mul_lat%0d: got %0d expected %0d", t_op[i], lat, MUL_LAT); end
            if (busy !== MUL_LAT - 1) begin n_mis++; $display("FAIL mul_busy%0d: got %0d expected %0d", t_op[i], busy, MUL_LAT - 1); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        logic stable;
        int lat;
        i_ready = 1'b0;
        exp_q.push_back(32'd14);
        i_op = DIVU; i_a = 32'd100; i_b = 32'd7; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat !== XLEN + 1) begin n_mis++; $display("FAIL bp_lat: got %0d expected %0d", lat, XLEN + 1); end
        i_op = ADD; i_a = 32'd2; i_b = 32'd3; i_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (o_valid !== 1'b1 || o_result !== exp_q[0] || o_ready !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
        end
        n_cmp++; if (stable !== 1'b1) begin n_mis++; $display("FAIL bp_hold: got unstable expected stable (result %h)", o_result); end
        exp_q.push_back(32'd5);
        i_ready = 1'b1; #1;
        exp = exp_q.pop_front();
        n_cmp += 2;
        if (o_ready !== 1'b1) begin n_mis++; $display("FAIL bp_ready: got %b expected 1", o_ready); end
        if (o_result !== exp) begin n_mis++; $display("FAIL bp_result: got %h expected %h", o_result, exp); end
        @(posedge clk); #1;
        i_valid = 1'b0;
        exp = exp_q.pop_front();
        n_cmp += 2;
        if (o_valid !== 1'b1) begin n_mis++; $display("FAIL bp_next_valid: got %b expected 1", o_valid); end
        if (o_result !== exp) begin n_mis++; $display("FAIL bp_next: got %h expected %h", o_result, exp); end
        @(posedge clk); #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_mis++; $display("FAIL bp_retire: got %b expected 0", o_valid); end
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] res, exp;
        int lat, busy;
        i_op = DIV; i_a = 32'hFFFF_FFF9; i_b = 32'd2; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_cmp++; if (o_busy !== 1'b1) begin n_mis++; $display("FAIL rst_pre_busy: got %b expected 1", o_busy); end
        rstn = 1'b0; #1;
        n_cmp += 3;
        if (o_valid !== 1'b0) begin n_mis++; $display("FAIL rst_mid_valid: got %b expected 0", o_valid); end
        if (o_result !== 32'd0) begin n_mis++; $display("FAIL rst_mid_result: got %h expected 0", o_result); end
        if (o_busy !== 1'b0) begin n_mis++; $display("FAIL rst_mid_busy: got %b expected 0", o_busy); end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(32'd2);
        do_op(ADD, 32'd1, 32'd1, res, lat, busy);
        exp = exp_q.pop_front();
        n_cmp += 2;
        if (res !== exp) begin n_mis++; $display("FAIL rst_add: got %h expected %h", res, exp); end
        if (lat !== 1) begin n_mis++; $display("FAIL rst_add_lat: got %0d expected 1", lat); end
    endtask

    initial begin
        #2;
        test_reset();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        test_back_to_back();
        test_base_ops();
        test_div();
        test_div_special();
        test_mul();
        test_backpressure();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/riscv_alu_mc.md
Name: riscv_alu_mc

Overview:
Parametrised multi-cycle execute unit that succeeds the single-cycle RV32I ALU. It adds the RV32M/RV64M multiply and divide ops and decouples the execute stage with valid/ready handshakes on both input and output. Base integer ops complete in 1 cycle. MUL/DIV families iterate one bit per cycle. Sits in EX between the decode/issue register and the writeback register.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
SHAMT_W, $clog2(XLEN), shift-amount width; derived, not overridden.
CNT_W, $clog2(XLEN)+1, iteration counter width; derived.

Ports:
i_clk  in  1  clock, rising edge.
i_rstn  in  1  asynchronous active-low reset.
i_valid  in  1  operation request.
o_ready  out  1  unit can accept a request this cycle.
i_op  in  5  op code: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; all others illegal.
i_a  in  XLEN  operand A (rs1).
i_b  in  XLEN  operand B (rs2/imm).
o_valid  out  1  result available.
i_ready  in  1  downstream accepts the result.
o_result  out  XLEN  registered result.
o_busy  out  1  high in MUL or DIV state.

Behaviour:
- Reset (async, i_rstn=0): state IDLE, o_valid=0, o_result=0, counter=0, internal operand/accumulator registers=0.
- o_ready = (state==IDLE) | (state==DONE & i_ready). A request is accepted when i_valid & o_ready. Operands and op are latched on acceptance; the unit never samples i_a/i_b after that.
- FSM states IDLE, MUL, DIV, DONE:
  - IDLE/DONE + accept, base op or illegal op -> DONE. Result is computed and registered that edge (latency 1). Illegal op -> result 0.
  - IDLE/DONE + accept, MUL family -> MUL, counter=XLEN.
  - IDLE/DONE + accept, DIV family, normal case -> DIV, counter=XLEN.
  - IDLE/DONE + accept, DIV family, special case -> DONE directly (latency 1).
  - MUL/DIV: decrement the counter each cycle. When the counter reaches 1, register the result and go to DONE. Total latency is XLEN+1 cycles from acceptance to o_valid.
  - DONE & i_ready & !i_valid -> IDLE, o_valid falls.
  - DONE & !i_ready -> hold. o_result and o_valid stay stable (no-drop rule).
- o_valid=1 exactly in DONE. Back-to-back: in DONE with i_ready & i_valid, a new request is accepted in the same cycle the old result retires.
- Arithmetic rules:
  - ADD/SUB/logic ops wrap modulo 2^XLEN.
  - Shifts use i_b[SHAMT_W-1:0] only. SRA is arithmetic.
  - SLT/SLTU return 1 or 0, zero-extended.
- MUL family uses a 2*XLEN-bit shift-add product:
  - MUL returns the low XLEN bits.
  - MULH returns the high half, signed×signed.
  - MULHSU returns the high half, signed A × unsigned B.
  - MULHU returns the high half, unsigned×unsigned.
  - Signed operands are converted to magnitudes and the product sign is restored at the final step.
- DIV family uses a restoring divider, one quotient bit per cycle. Signed ops divide magnitudes, then fix signs: quotient negative if signs differ; remainder takes the dividend's sign.
- Special cases (never raise an exception):
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> i_a.
  - Signed overflow (A = most-negative, B = -1): DIV -> most-negative; REM -> 0.
- o_busy = (state==MUL | state==DIV). While busy, o_ready=0 and i_valid is ignored.
- Reset mid-operation: the operation is abandoned, state goes to IDLE, no result is produced.

Optional Feature:
RISCV_ALU_FAST_MUL_EN
- Defined: MUL, MULH, MULHSU and MULHU use a single combinational XLEN×XLEN multiplier. They take the base-op path with latency 1, and the MUL state is unreachable.
- Undefined: iterative shift-add multiplier with latency XLEN+1, as described above.
- DIV behaviour is identical in both builds.

Test Plan:
- ADD i_a=5, i_b=7; SUB 3-5 back-to-back with i_ready=1 -> o_result=12 one cycle after acceptance, then 0xFFFFFFFE the next cycle; o_ready stays 1 throughout.
- DIV i_a=0xFFFFFFF9 (-7), i_b=2 -> o_valid 33 cycles after acceptance, o_result=0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). o_busy high for 32 cycles.
- DIVU i_a=0x1234, i_b=0 -> 0xFFFFFFFF with latency 1. REMU same operands -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE. Latency 33, or 1 with RISCV_ALU_FAST_MUL_EN defined.
- Backpressure: i_ready=0 for 10 cycles after a DIVU result -> o_valid and o_result stable, o_ready=0, new i_valid ignored. i_ready=1 -> result retires and the pending request is accepted in that cycle.
- Assert i_rstn=0 mid-DIV at cycle 10 -> o_valid=0, o_result=0, o_busy=0 immediately. After release, ADD 1+1 -> 2 with latency 1.
